// File: rtl/traffic_ctrl_pkg.sv
// Shared definitions for the intersection controller: phase encodings, lamp
// codes and the phase-to-lamp decode used by the controller's output stage.
package traffic_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED_B   = 3'd6
    } phase_e;

    // Lamp heads are {R,Y,G} one-hot
    localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [LAMP_W-1:0] main;
        logic [LAMP_W-1:0] side;
        logic              walk;
    } lamps_t;

    // Moore decode: any head not explicitly lit is red; unknown phases fail safe to all-red
    function automatic lamps_t decode_lamps(input phase_e ph);
        lamps_t l;
        l.main = LAMP_R;
        l.side = LAMP_R;
        l.walk = 1'b0;
        case (ph)
            MAIN_GREEN:  l.main = LAMP_G;
            MAIN_YELLOW: l.main = LAMP_Y;
            PED_WALK:    l.walk = 1'b1;
            SIDE_GREEN:  l.side = LAMP_G;
            SIDE_YELLOW: l.side = LAMP_Y;
            default:     ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts ticks spent in the current phase, saturating at all-ones.
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset
//   clear_i   restart count from zero (phase change); has priority over tick
//   tick_i    timebase strobe
//   count_o   current count
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (tick_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Phase sequencer for a main/side intersection with a pedestrian crossing.
// Latches side-road and pedestrian demand, times each phase on the tick
// timebase and drives the lamp heads. Main road rests in green without demand.
// Ports:
//   clk_i               clock
//   reset_i             synchronous active-high reset
//   tick_i              timebase strobe (tie high for clock-cycle units)
//   vehicle_detected_i  side-road vehicle present (level)
//   ped_detected_i      pedestrian button (level or pulse)
//   main_light_o        main head {R,Y,G}
//   side_light_o        side head {R,Y,G}
//   walk_o              pedestrian WALK lamp
//   ped_req_pending_o   latched pedestrian demand
//   phase_o             current phase encoding (debug)
module traffic_phase_controller
    import traffic_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic              vehicle_detected_i,
    input  logic              ped_detected_i,
    output logic [LAMP_W-1:0] main_light_o,
    output logic [LAMP_W-1:0] side_light_o,
    output logic              walk_o,
    output logic              ped_req_pending_o,
    output logic [STATE_W-1:0] phase_o
);

    // A phase of N ticks expires on the tick where the count has reached N-1
    localparam logic [CNT_W-1:0] MIN_G_LIM  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_LIM  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LIM   = CNT_W'(WALK_T - 1);

    phase_e           state_q, state_d;
    logic             side_req_q, side_req_d;
    logic             ped_req_q, ped_req_d;
    lamps_t           lamps_q, lamps_d;
    logic [CNT_W-1:0] timer;
    logic             timer_clr;

    logic exp_min_g, exp_max_g, exp_yellow, exp_allred, exp_walk;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (timer_clr),
        .tick_i  (tick_i),
        .count_o (timer)
    );

    assign exp_min_g  = tick_i && (timer >= MIN_G_LIM);
    assign exp_max_g  = tick_i && (timer >= MAX_G_LIM);
    assign exp_yellow = tick_i && (timer >= YELLOW_LIM);
    assign exp_allred = tick_i && (timer >= ALLRED_LIM);
    assign exp_walk   = tick_i && (timer >= WALK_LIM);

    // Next phase, demand latches and next lamp pattern
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (exp_min_g && (side_req_q || ped_req_q)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (exp_yellow) state_d = ALL_RED_A;
            ALL_RED_A:   if (exp_allred) state_d = ped_req_q ? PED_WALK : SIDE_GREEN;
            PED_WALK:    if (exp_walk) state_d = ALL_RED_B;
            SIDE_GREEN:  if ((exp_min_g && !vehicle_detected_i) || exp_max_g) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (exp_yellow) state_d = ALL_RED_B;
            ALL_RED_B:   if (exp_allred) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase

        // Servicing a request clears it even if new demand arrives the same cycle
        side_req_d = (state_d == SIDE_GREEN) ? 1'b0
                   : (side_req_q || (vehicle_detected_i && (state_q != SIDE_GREEN)));
        ped_req_d  = (state_d == PED_WALK) ? 1'b0
                   : (ped_req_q || (ped_detected_i && (state_q != PED_WALK)));

        lamps_d   = decode_lamps(state_d);
        timer_clr = (state_d != state_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= MAIN_GREEN;
            side_req_q <= 1'b0;
            ped_req_q  <= 1'b0;
            lamps_q    <= '{main: LAMP_G, side: LAMP_R, walk: 1'b0};
        end else begin
            state_q    <= state_d;
            side_req_q <= side_req_d;
            ped_req_q  <= ped_req_d;
            lamps_q    <= lamps_d;
        end
    end

    assign main_light_o      = lamps_q.main;
    assign side_light_o      = lamps_q.side;
    assign walk_o            = lamps_q.walk;
    assign ped_req_pending_o = ped_req_q;
    assign phase_o           = STATE_W'(state_q);

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed timelines plus
// randomized traffic checked against a phase/duration reference model.
module tb_traffic_phase_controller;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       tick_i = 1'b1;
    logic       vehicle_detected_i = 1'b0;
    logic       ped_detected_i = 1'b0;
    logic [2:0] main_light_o;
    logic [2:0] side_light_o;
    logic       walk_o;
    logic       ped_req_pending_o;
    logic [2:0] phase_o;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_phase_controller dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .tick_i             (tick_i),
        .vehicle_detected_i (vehicle_detected_i),
        .ped_detected_i     (ped_detected_i),
        .main_light_o       (main_light_o),
        .side_light_o       (side_light_o),
        .walk_o             (walk_o),
        .ped_req_pending_o  (ped_req_pending_o),
        .phase_o            (phase_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    // Phases: 0 main green, 1 main yellow, 2 all red A, 3 walk,
    //         4 side green, 5 side yellow, 6 all red B
    localparam int MIN_G = 4, MAX_G = 8, YEL = 2, ARED = 1, WALK = 3;
    logic [2:0] main_tbl [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tbl [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_ph;       // current phase
    int m_ticks;    // ticks elapsed in current phase
    bit m_side;     // outstanding side-road demand
    bit m_ped;      // outstanding pedestrian demand

    function automatic bit done(input int ticks, input int dur, input bit tk);
        return tk && (ticks + 1 >= dur);
    endfunction

    task automatic model_step();
        int nxt;
        if (reset_i) begin
            m_ph = 0; m_ticks = 0; m_side = 0; m_ped = 0;
            return;
        end
        nxt = m_ph;
        case (m_ph)
            0: if (done(m_ticks, MIN_G, tick_i) && (m_side || m_ped)) nxt = 1;
            1: if (done(m_ticks, YEL, tick_i)) nxt = 2;
            2: if (done(m_ticks, ARED, tick_i)) nxt = m_ped ? 3 : 4;
            3: if (done(m_ticks, WALK, tick_i)) nxt = 6;
            4: if ((done(m_ticks, MIN_G, tick_i) && !vehicle_detected_i) ||
                   done(m_ticks, MAX_G, tick_i)) nxt = 5;
            5: if (done(m_ticks, YEL, tick_i)) nxt = 6;
            default: if (done(m_ticks, ARED, tick_i)) nxt = 0;
        endcase
        if (vehicle_detected_i && m_ph != 4) m_side = 1;
        if (ped_detected_i && m_ph != 3) m_ped = 1;
        if (nxt == 4) m_side = 0;
        if (nxt == 3) m_ped = 0;
        if (nxt != m_ph) m_ticks = 0;
        else if (tick_i && m_ticks < 255) m_ticks++;
        m_ph = nxt;
    endtask

    function automatic logic [10:0] model_vec();
        return {3'(m_ph), main_tbl[m_ph], side_tbl[m_ph], (m_ph == 3), m_ped};
    endfunction

    logic [10:0] obs_vec;
    assign obs_vec = {phase_o, main_light_o, side_light_o, walk_o, ped_req_pending_o};

    // Advance one clock; returns at the following negedge with the model in step
    task automatic step();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    // Leaves the bench at cycle 0 (first cycle after reset release)
    task automatic do_reset();
        reset_i = 1'b1; tick_i = 1'b1; vehicle_detected_i = 1'b0; ped_detected_i = 1'b0;
        step();
        reset_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1'b1; vehicle_detected_i = 1'b1; ped_detected_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs_vec !== 11'b000_001_100_0_0) begin
                n_fail++;
                $display("FAIL reset_held i=%0d got=%h exp=%h", i, obs_vec, 11'b000_001_100_0_0);
            end
        end
        do_reset();
        for (int c = 0; c < 30; c++) begin
            n_tests++;
            if (obs_vec !== 11'b000_001_100_0_0 || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL no_demand c=%0d got=%h exp=%h", c, obs_vec, model_vec());
            end
            step();
        end
    endtask

    task automatic test_vehicle_maxout();
        int ep;
        do_reset();
        vehicle_detected_i = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            ep = (c < 4) ? 0 : (c < 6) ? 1 : (c == 6) ? 2 : (c < 15) ? 4 :
                 (c < 17) ? 5 : (c == 17) ? 6 : 0;
            n_tests++;
            if (int'(phase_o) != ep || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL vehicle_maxout c=%0d got_phase=%0d exp_phase=%0d got=%h model=%h",
                         c, phase_o, ep, obs_vec, model_vec());
            end
            step();
        end
        vehicle_detected_i = 1'b0;
    endtask

    task automatic test_ped_pulse();
        int ep;
        bit epend, ewalk;
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            ped_detected_i = (c == 10);
            ep = (c < 12) ? 0 : (c < 14) ? 1 : (c == 14) ? 2 : (c < 18) ? 3 :
                 (c == 18) ? 6 : 0;
            epend = (c >= 11 && c <= 14);
            ewalk = (c >= 15 && c <= 17);
            n_tests++;
            if (int'(phase_o) != ep || ped_req_pending_o !== epend || walk_o !== ewalk ||
                obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL ped_pulse c=%0d got=%h exp_phase=%0d exp_pend=%0d exp_walk=%0d model=%h",
                         c, obs_vec, ep, epend, ewalk, model_vec());
            end
            step();
        end
        ped_detected_i = 1'b0;
    endtask

    task automatic test_vehicle_gapout();
        int ep;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            vehicle_detected_i = (c == 0);
            ep = (c < 4) ? 0 : (c < 6) ? 1 : (c == 6) ? 2 : (c < 11) ? 4 :
                 (c < 13) ? 5 : (c == 13) ? 6 : 0;
            n_tests++;
            if (int'(phase_o) != ep || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL vehicle_gapout c=%0d got_phase=%0d exp_phase=%0d got=%h model=%h",
                         c, phase_o, ep, obs_vec, model_vec());
            end
            step();
        end
        vehicle_detected_i = 1'b0;
    endtask

    task automatic test_both_demand();
        int ep;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            vehicle_detected_i = (c == 0);
            ped_detected_i     = (c == 0);
            ep = (c < 4) ? 0 : (c < 6) ? 1 : (c == 6) ? 2 : (c < 10) ? 3 :
                 (c == 10) ? 6 : (c < 15) ? 0 : (c < 17) ? 1 : (c == 17) ? 2 : 4;
            n_tests++;
            if (int'(phase_o) != ep || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL both_demand c=%0d got_phase=%0d exp_phase=%0d got=%h model=%h",
                         c, phase_o, ep, obs_vec, model_vec());
            end
            step();
        end
        vehicle_detected_i = 1'b0;
        ped_detected_i     = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            ped_detected_i     = (c == 0);
            vehicle_detected_i = (c == 1);
            reset_i            = (c == 8);
            if (c == 7 || c == 8) begin
                n_tests++;
                if (walk_o !== 1'b1 || phase_o !== 3'd3) begin
                    n_fail++;
                    $display("FAIL mid_walk_pre c=%0d got_walk=%0d got_phase=%0d exp_walk=1 exp_phase=3",
                             c, walk_o, phase_o);
                end
            end
            // Latches cleared by reset: main must rest in green from c9 on
            if (c >= 9) begin
                n_tests++;
                if (obs_vec !== 11'b000_001_100_0_0 || obs_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL mid_walk_reset c=%0d got=%h exp=%h", c, obs_vec, 11'b000_001_100_0_0);
                end
            end
            step();
        end
        reset_i = 1'b0; vehicle_detected_i = 1'b0; ped_detected_i = 1'b0;
    endtask

    task automatic test_tick_freeze();
        int ep;
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            vehicle_detected_i = (c == 0);
            tick_i = !(c >= 4 && c <= 8);
            ep = (c < 4) ? 0 : (c < 11) ? 1 : (c == 11) ? 2 : 4;
            n_tests++;
            if (int'(phase_o) != ep || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL tick_freeze c=%0d got_phase=%0d exp_phase=%0d got=%h model=%h",
                         c, phase_o, ep, obs_vec, model_vec());
            end
            step();
        end
        tick_i = 1'b1; vehicle_detected_i = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick_i             = ($urandom_range(3) != 0);
            vehicle_detected_i = ($urandom_range(5) == 0) || (vehicle_detected_i && $urandom_range(2) != 0);
            ped_detected_i     = ($urandom_range(15) == 0);
            reset_i            = ($urandom_range(127) == 0);
            n_tests++;
            if (obs_vec !== model_vec()) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random_model c=%0d got=%h exp=%h", c, obs_vec, model_vec());
                errs++;
            end
            n_tests++;
            if ((main_light_o[0] && side_light_o[0]) ||
                (walk_o && (main_light_o !== 3'b100 || side_light_o !== 3'b100))) begin
                n_fail++;
                $display("FAIL random_safety c=%0d got_main=%b got_side=%b got_walk=%0d exp=no_conflict",
                         c, main_light_o, side_light_o, walk_o);
            end
            step();
        end
        reset_i = 1'b0; tick_i = 1'b1; vehicle_detected_i = 1'b0; ped_detected_i = 1'b0;
    endtask

    initial begin
        m_ph = 0; m_ticks = 0; m_side = 0; m_ped = 0;
        @(negedge clk_i);
        test_reset();
        test_vehicle_maxout();
        test_ped_pulse();
        test_vehicle_gapout();
        test_both_demand();
        test_reset_mid_walk();
        test_tick_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
